// File: rtl/led_sequencer.sv
// LED count sequencer: steps count up, down or ping-pong on a go rising edge, paced by a clock-enable divider.
// Optional hold input enabled by defining LEDSEQ_PAUSE_EN.
module led_sequencer #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
   parameter int unsigned TICK_DIV  = 1500000,
   parameter int unsigned LOOPS     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             abort,
   input  logic [1:0]       mode,
`ifdef LEDSEQ_PAUSE_EN
   input  logic             pause,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [WIDTH-1:0]  MAX_C     = WIDTH'(MAX_COUNT);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
   localparam logic [1:0]        MODE_DOWN = 2'b01;
   localparam logic [1:0]        MODE_PP   = 2'b10;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic              go_q;
   logic [1:0]        mode_q;
   logic              dir_down;
   logic [DIV_W-1:0]  div;
   logic [LOOP_W-1:0] loop_cnt;

   logic              hold;
   logic              start;
   logic              tick;
   logic              seq_end;
   logic              step_dir_down;
   logic [WIDTH-1:0]  step_count;

`ifdef LEDSEQ_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   // abort in the same cycle as a go edge suppresses the start
   assign start = (state == IDLE) && go && !go_q && !abort;
   assign tick  = (state == RUN) && !hold && (div == DIV_LAST);

   function automatic logic [WIDTH-1:0] start_of(input logic [1:0] m);
      return (m == MODE_DOWN) ? MAX_C : '0;
   endfunction

   // Next value on a tick, or end-of-sequence flag when the current pass is complete
   always_comb begin
      seq_end       = 1'b0;
      step_count    = count;
      step_dir_down = dir_down;
      case (mode_q)
         MODE_DOWN: begin
            if (count != '0) step_count = count - WIDTH'(1);
            else             seq_end    = 1'b1;
         end
         MODE_PP: begin
            if (!dir_down) begin
               step_count = count + WIDTH'(1);
               if (step_count == MAX_C) step_dir_down = 1'b1;
            end else if (count != '0) begin
               step_count = count - WIDTH'(1);
            end else begin
               seq_end = 1'b1;
            end
         end
         default: begin
            if (count < MAX_C) step_count = count + WIDTH'(1);
            else               seq_end    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         go_q     <= 1'b0;
         mode_q   <= 2'b00;
         dir_down <= 1'b0;
         div      <= '0;
         loop_cnt <= '0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         go_q <= go;
         done <= 1'b0;
         case (state)
            IDLE: begin
               div <= '0;
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  mode_q   <= mode;
                  count    <= start_of(mode);
                  loop_cnt <= '0;
                  dir_down <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  count <= '0;
                  div   <= '0;
               end else if (tick) begin
                  div <= '0;
                  if (!seq_end) begin
                     count    <= step_count;
                     dir_down <= step_dir_down;
                  end else if (loop_cnt == LOOP_LAST) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     count <= '0;
                     done  <= 1'b1;
                  end else begin
                     loop_cnt <= loop_cnt + LOOP_W'(1);
                     count    <= start_of(mode_q);
                     dir_down <= 1'b0;
                  end
               end else if (!hold) begin
                  div <= div + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: expected output changes are queued with their edge number
// and a negedge monitor pops one entry each time a DUT's outputs change.
module tb_led_sequencer;

   typedef struct {
      int         cyc;
      logic [3:0] count;
      logic       busy;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go = 1'b0;
   logic       go2 = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] mode = 2'b00;
`ifdef LEDSEQ_PAUSE_EN
   logic       pause = 1'b0;
`endif
   logic [3:0] count1, count2;
   logic       busy1, busy2, done1, done2;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   exp_t q1[$];
   exp_t q2[$];
   logic [5:0] prev1 = 6'd0;
   logic [5:0] prev2 = 6'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led_sequencer #(.WIDTH(4), .MAX_COUNT(3), .TICK_DIV(4), .LOOPS(1)) dut1 (
      .clk(clk), .rst(rst), .go(go), .abort(abort), .mode(mode),
`ifdef LEDSEQ_PAUSE_EN
      .pause(pause),
`endif
      .count(count1), .busy(busy1), .done(done1));

   led_sequencer #(.WIDTH(4), .MAX_COUNT(3), .TICK_DIV(4), .LOOPS(2)) dut2 (
      .clk(clk), .rst(rst), .go(go2), .abort(abort), .mode(mode),
`ifdef LEDSEQ_PAUSE_EN
      .pause(1'b0),
`endif
      .count(count2), .busy(busy2), .done(done2));

   task automatic e1(input int c, input int v, input logic b, input logic d);
      exp_t e;
      e.cyc = c; e.count = 4'(v); e.busy = b; e.done = d;
      q1.push_back(e);
   endtask

   task automatic e2(input int c, input int v, input logic b, input logic d);
      exp_t e;
      e.cyc = c; e.count = 4'(v); e.busy = b; e.done = d;
      q2.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, need %0d", name, act, req);
      end
   endtask

   task automatic check_step(input string tag, input exp_t e, input logic [3:0] c,
                             input logic b, input logic d);
      n_cmp++;
      if (e.cyc != cyc || e.count !== c || e.busy !== b || e.done !== d) begin
         n_bad++;
         $display("FAIL %s step: got cyc=%0d count=%0d busy=%0d done=%0d, need cyc=%0d count=%0d busy=%0d done=%0d",
                  tag, cyc, c, b, d, e.cyc, e.count, e.busy, e.done);
      end
   endtask

   // Monitor: every output change of each DUT must match the next queued expectation
   always @(negedge clk) begin
      exp_t e;
      if ({count1, busy1, done1} !== prev1) begin
         if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL dut1 unexpected change: got cyc=%0d count=%0d busy=%0d done=%0d, need no change",
                     cyc, count1, busy1, done1);
         end else begin
            e = q1.pop_front();
            check_step("dut1", e, count1, busy1, done1);
         end
         prev1 = {count1, busy1, done1};
      end
      if ({count2, busy2, done2} !== prev2) begin
         if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL dut2 unexpected change: got cyc=%0d count=%0d busy=%0d done=%0d, need no change",
                     cyc, count2, busy2, done2);
         end else begin
            e = q2.pop_front();
            check_step("dut2", e, count2, busy2, done2);
         end
         prev2 = {count2, busy2, done2};
      end
   end

   // Returns just after edge e-1 so the values driven next are sampled at edge e
   task automatic sync(input int e);
      while (cyc < e - 1) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got time limit reached, need run complete");
      $fatal(1);
   end

   initial begin
      #1;
      chk("reset count1", 32'(count1), 0);
      chk("reset busy1", 32'(busy1), 0);
      chk("reset done1", 32'(done1), 0);
      chk("reset count2", 32'(count2), 0);
      chk("reset busy2", 32'(busy2), 0);
      sync(3); rst = 1'b0;

      // up, then down started at the earliest edge after done
      e1(10, 0, 1, 0); e1(14, 1, 1, 0); e1(18, 2, 1, 0); e1(22, 3, 1, 0); e1(26, 0, 0, 1);
      e1(27, 3, 1, 0); e1(31, 2, 1, 0); e1(35, 1, 1, 0); e1(39, 0, 1, 0); e1(43, 0, 0, 1);
      e1(44, 0, 0, 0);
      sync(10); go = 1'b1; mode = 2'b00;
      sync(11); go = 1'b0;
      sync(27); go = 1'b1; mode = 2'b01;
      sync(28); go = 1'b0;

      // abort coinciding with a go edge in IDLE: no start
      sync(50); go = 1'b1; abort = 1'b1; mode = 2'b00;
      sync(51); go = 1'b0; abort = 1'b0;
      sync(53); chk("abort+go busy", 32'(busy1), 0);

      // abort mid-run with go held high; no retrigger
      e1(60, 0, 1, 0); e1(64, 1, 1, 0); e1(66, 0, 0, 0);
      sync(60); go = 1'b1;
      sync(66); abort = 1'b1;
      sync(67); abort = 1'b0;
      sync(81); go = 1'b0;

      // async reset mid-run, then a fresh full run
      e1(90, 0, 1, 0); e1(94, 1, 1, 0); e1(98, 2, 1, 0); e1(99, 0, 0, 0);
      e1(105, 0, 1, 0); e1(109, 1, 1, 0); e1(113, 2, 1, 0); e1(117, 3, 1, 0);
      e1(121, 0, 0, 1); e1(122, 0, 0, 0);
      sync(90); go = 1'b1;
      sync(91); go = 1'b0;
      sync(100); rst = 1'b1;
      sync(102); rst = 1'b0;
      sync(105); go = 1'b1;
      sync(106); go = 1'b0;

      // ping-pong, two loops; the loop restart at 158 keeps count at 0
      e2(130, 0, 1, 0); e2(134, 1, 1, 0); e2(138, 2, 1, 0); e2(142, 3, 1, 0);
      e2(146, 2, 1, 0); e2(150, 1, 1, 0); e2(154, 0, 1, 0);
      e2(162, 1, 1, 0); e2(166, 2, 1, 0); e2(170, 3, 1, 0);
      e2(174, 2, 1, 0); e2(178, 1, 1, 0); e2(182, 0, 1, 0);
      e2(186, 0, 0, 1); e2(187, 0, 0, 0);
      sync(130); go2 = 1'b1; mode = 2'b10;
      sync(131); go2 = 1'b0;

      // mode 11 behaves as up, two loops; mode changed after start is ignored
      e2(200, 0, 1, 0); e2(204, 1, 1, 0); e2(208, 2, 1, 0); e2(212, 3, 1, 0);
      e2(216, 0, 1, 0); e2(220, 1, 1, 0); e2(224, 2, 1, 0); e2(228, 3, 1, 0);
      e2(232, 0, 0, 1); e2(233, 0, 0, 0);
      sync(200); go2 = 1'b1; mode = 2'b11;
      sync(201); go2 = 1'b0; mode = 2'b01;

`ifdef LEDSEQ_PAUSE_EN
      e1(250, 0, 1, 0); e1(254, 1, 1, 0); e1(268, 2, 1, 0); e1(272, 3, 1, 0);
      e1(276, 0, 0, 1); e1(277, 0, 0, 0);
      sync(250); go = 1'b1; mode = 2'b00;
      sync(251); go = 1'b0;
      sync(255); pause = 1'b1;
      sync(260); chk("pause busy", 32'(busy1), 1);
      sync(265); pause = 1'b0;
`endif

      sync(300);
      chk("dut1 pending expectations", 32'(q1.size()), 0);
      chk("dut2 pending expectations", 32'(q2.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED count sequencer: the next generation of the board-level go/done counting FSM. On a `go` rising edge it steps a `WIDTH`-bit `count` through an up, down or ping-pong sequence at a rate set by an internal clock-enable divider. It can repeat the sequence `LOOPS` times and signals completion with a one-cycle `done` pulse. It sits between the synchronised push-button logic and the LED pins, and runs entirely in the `clk` domain with no derived clocks.

## Interface
- `WIDTH`, 4: width of `count`; legal range 1..16.
- `MAX_COUNT`, 2**WIDTH-1: sequence end value; 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- `TICK_DIV`, 1500000: clk cycles per step; ≥ 1 (1 = step every cycle).
- `LOOPS`, 1: number of sequence repetitions per start; ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `go`  in  1  start request, synchronous, active-high, rising-edge detected.
- `abort`  in  1  synchronous, active-high; cancels a run without `done`.
- `mode`  in  2  00 up, 01 down, 10 ping-pong, 11 treated as up; latched at start.
- `pause`  in  1  hold request (present only with `LEDSEQ_PAUSE_EN`).
- `count`  out  WIDTH  sequence value, registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse, registered.

## Operation
- States: IDLE, RUN.
- Reset values: state IDLE, `count`=0, `busy`=0, `done`=0, divider=0, loop counter=0, `go_q`=0, direction=up.
- `go_q` is `go` registered every cycle. A start is `go & ~go_q` while in IDLE.
- IDLE → RUN on start:
  - latch `mode`;
  - `count` ← start value (0 for up and ping-pong, MAX_COUNT for down);
  - loop counter ← 0, direction ← up (ping-pong), divider ← 0.
- `go` while in RUN is ignored; a held `go` never retriggers.
- Divider counts 0..TICK_DIV-1 and wraps. `tick` is the internal term `divider == TICK_DIV-1` in RUN. The divider is held at 0 in IDLE.
- On `tick` in RUN:
  - up: if `count` < MAX_COUNT then `count`+1, else end of sequence.
  - down: if `count` > 0 then `count`-1, else end of sequence.
  - ping-pong, direction up: `count`+1; on reaching MAX_COUNT, direction ← down.
  - ping-pong, direction down: `count`-1 while `count` > 0; `count` == 0 with direction down is end of sequence.
  - MAX_COUNT=1 in ping-pong runs 0,1,0.
- End of sequence:
  - if loop counter == LOOPS-1: state ← IDLE, `count` ← 0, `done` ← 1;
  - else: loop counter+1, `count` ← start value, direction ← up.
- `abort` in RUN: state ← IDLE, `count` ← 0, divider ← 0, no `done`. `abort` has priority over `tick`.
- `abort` together with a start in IDLE: no start occurs.
- `done` clears on the following cycle unconditionally.
- Arithmetic is unsigned. `count` never exceeds MAX_COUNT or wraps below 0.
- Asserting `rst` mid-run forces reset values immediately; no `done` is produced.

## Timing
- Start sampled at edge N: `busy`=1 and `count`=start value after edge N.
- First step at edge N+TICK_DIV; step k lands at edge N+k·TICK_DIV.
- Final tick at edge M: after edge M, `busy`=0, `count`=0 and `done`=1. After M+1, `done`=0.
- Total run length for up/down with LOOPS=L: L·(MAX_COUNT+1)·TICK_DIV cycles from start to `done`.
- Ping-pong total: L·(2·MAX_COUNT+1)·TICK_DIV cycles.
- A new start is accepted at edge M+1 at the earliest, provided `go` was low at edge M.

## Configuration
- `LEDSEQ_PAUSE_EN` defined:
  - `pause` port exists.
  - While `pause`=1 in RUN, the divider and `count` hold; `busy` stays 1.
  - `abort` still acts during pause.
  - Releasing `pause` resumes from the held divider value.
- Not defined: no `pause` port; the run is never stalled.

## Test plan
- WIDTH=4, MAX_COUNT=3, TICK_DIV=4, LOOPS=1, mode up, `go` pulse at edge 0 → `count` 0,1,2,3 at edges 0,4,8,12; `done`=1 only after edge 16; `count`=0 and `busy`=0 from edge 16.
- Same config, mode down → `count` 3,2,1,0 at edges 0,4,8,12; `done` after edge 16.
- Mode ping-pong, LOOPS=2 → `count` sequence 0,1,2,3,2,1,0,0,1,2,3,2,1,0; one `done` pulse after edge 56.
- `abort` at edge 6 in up mode → `busy`=0 and `count`=0 after edge 6; `done` never asserts. `go` held high from edge 0 through edge 20 → no restart.
- `rst` asserted at edge 9 mid-run → all outputs 0 asynchronously. A new `go` edge after release restarts from 0.
- With `LEDSEQ_PAUSE_EN`, `pause` high during edges 5..14 in up mode → `count` holds at 1; remaining steps shift by 10 cycles; `done` after edge 26.
